// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I pipeline types and constants
package rv32_pkg;

  // addi x0, x0, 0: what decode sees when fetch has nothing to offer
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // default fetch buffer depth (outstanding requests + buffered instructions)
  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - flushable synchronous FIFO used for fetch buffering and pc tags
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  T                         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output T                         o_head
);

  localparam int             AW   = $clog2(DEPTH);
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;

  // a pop on an empty queue is ignored so callers need not qualify it
  assign w_do_pop = i_pop & (r_count != '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rd_ptr];

  // pointers and occupancy; flush discards everything, including a same-cycle push
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_do_pop);
    end
  end

  // storage needs no reset: the head is only meaningful while count is non-zero
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  // a push into a full queue would silently lose an entry
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush) assert (!(i_push && !w_do_pop && r_count == FULL));
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch: PC, imem requests, flushable buffer to ID
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_pc4
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_pc, w_pc_next;
  logic [CW-1:0] r_outst, w_outst_next;
  logic [CW-1:0] r_drop_cnt, w_drop_next;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_tag_count;
  logic [CW:0]   w_used;
  logic          w_pop;
  logic          w_issue;
  logic          w_req_valid;
  logic          w_rsp_keep;
  logic [31:0]   w_tag_pc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_rsp_entry;

  // credits cover both in-flight requests and buffered instructions, so the buffer never overflows
  assign o_id_valid       = (w_count != '0);
  assign w_pop            = o_id_valid & ~i_stall & ~i_redirect_valid;
  assign w_used           = {1'b0, r_outst} + {1'b0, w_count} - (CW+1)'(w_pop);
  assign w_req_valid      = i_rst_n & ~i_redirect_valid & (w_used < CREDITS);
  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign w_issue          = w_req_valid & i_imem_req_ready;

  // while draining, in-order responses are stale until drop_cnt reaches zero
  assign w_rsp_keep  = i_imem_rsp_valid & (r_state == S_RUN) & ~i_redirect_valid;
  assign w_rsp_entry = '{pc: w_tag_pc, instr: i_imem_rsp_data};

  // outputs come straight from registered FIFO state, never from the response bus
  assign o_id_instr = o_id_valid ? w_head.instr : NOP_INSTR;
  assign o_id_pc    = o_id_valid ? w_head.pc : 32'h0;
  assign o_id_pc4   = o_id_pc + 32'd4;

  // issue-order address tags; every response (kept or dropped) retires one tag
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_tag_q (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_issue),
    .i_push_data (r_pc),
    .i_pop       (i_imem_rsp_valid),
    .i_flush     (1'b0),
    .o_count     (w_tag_count),
    .o_head      (w_tag_pc)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_rsp_keep),
    .i_push_data (w_rsp_entry),
    .i_pop       (w_pop),
    .i_flush     (i_redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // next PC, credit counters and drain state; a redirect overrides stall and issue
  always_comb begin
    w_pc_next    = r_pc;
    w_outst_next = r_outst;
    w_drop_next  = r_drop_cnt;
    w_state_next = r_state;
    if (i_redirect_valid) begin
      w_pc_next    = {i_redirect_pc[31:2], 2'b00};
      w_outst_next = r_outst - CW'(i_imem_rsp_valid);
      w_drop_next  = w_outst_next;
      w_state_next = (w_outst_next != '0) ? S_DRAIN : S_RUN;
    end else begin
      if (w_issue) w_pc_next = r_pc + 32'd4;
      w_outst_next = r_outst + CW'(w_issue) - CW'(i_imem_rsp_valid);
      case (r_state)
        S_RUN: ;
        S_DRAIN: begin
          if (i_imem_rsp_valid) begin
            w_drop_next = r_drop_cnt - CW'(1);
            if (r_drop_cnt == CW'(1)) w_state_next = S_RUN;
          end
        end
        default: w_state_next = S_RUN;
      endcase
    end
  end

  // state register for the drain FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_RUN;
    else          r_state <= w_state_next;
  end

  // PC and credit counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc       <= RESET_PC;
      r_outst    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_outst    <= w_outst_next;
      r_drop_cnt <= w_drop_next;
    end
  end

  // unsolicited responses or tag/credit disagreement mean the memory contract is broken
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_imem_rsp_valid && r_outst == '0));
      assert (w_tag_count == r_outst);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  int          cyc = 0;
  int          lat = 1;
  bit          rand_ready = 1'b0;
  logic [31:0] exp_pc, exp_req;
  int          live = 0;
  int          pops = 0;
  logic        s_req_valid, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc, s_id_pc4, s_id_instr;
  logic [31:0] frozen;
  bit          found;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect_valid (redir_valid),
    .i_redirect_pc    (redir_pc),
    .i_stall          (stall),
    .o_id_valid       (id_valid),
    .o_id_instr       (id_instr),
    .o_id_pc          (id_pc),
    .o_id_pc4         (id_pc4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive the memory response, sample before the edge, update the reference model
  task automatic cycle();
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'hDEAD_BEEF;
    end
    if (rand_ready) req_ready = 1'($urandom_range(0, 1));
    #1;
    s_req_valid = req_valid;
    s_req_addr  = req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_id_pc4    = id_pc4;
    s_id_instr  = id_instr;
    if (rst_n) begin
      if (redir_valid) begin
        chk("no_req_on_redirect", 32'(req_valid), 32'd0);
        exp_pc  = {redir_pc[31:2], 2'b00};
        exp_req = exp_pc;
        live    = 0;
      end else begin
        if (req_valid && req_ready) begin
          chk("req_align", req_addr & 32'd3, 32'd0);
          chk("req_addr", req_addr, exp_req);
          pend.push_back('{addr: req_addr, due: cyc + lat});
          exp_req = exp_req + 32'd4;
          live++;
        end
        if (id_valid && !stall) begin
          chk("id_pc", id_pc, exp_pc);
          chk("id_pc4", id_pc4, exp_pc + 32'd4);
          chk("id_instr", id_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          live--;
          pops++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    redir_valid = 1'b0; redir_pc = '0; stall = 1'b0;
    exp_pc = 32'h0; exp_req = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, NOP_INSTR);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h4);
    chk("rst_req_valid", 32'(req_valid), 32'd0);

    // streaming at latency 1
    rst_n = 1'b1;
    cycle();
    chk("t1_c0_req_valid", 32'(s_req_valid), 32'd1);
    chk("t1_c0_addr", s_req_addr, 32'h0);
    chk("t1_c0_id_valid", 32'(s_id_valid), 32'd0);
    cycle();
    chk("t1_c1_addr", s_req_addr, 32'h4);
    chk("t1_c1_id_valid", 32'(s_id_valid), 32'd0);
    cycle();
    chk("t1_c2_addr", s_req_addr, 32'h8);
    chk("t1_c2_id_valid", 32'(s_id_valid), 32'd1);
    chk("t1_c2_id_pc", s_id_pc, 32'h0);
    chk("t1_c2_id_pc4", s_id_pc4, 32'h4);
    cycle();
    chk("t1_c3_id_pc", s_id_pc, 32'h4);
    cycle();
    chk("t1_c4_id_pc", s_id_pc, 32'h8);
    repeat (6) begin
      cycle();
      chk("t1_throughput", 32'(s_id_valid), 32'd1);
    end

    // stall for 5 cycles: head frozen, credits cap the outstanding+buffered total
    stall = 1'b1;
    cycle();
    frozen = s_id_pc;
    repeat (4) begin
      cycle();
      chk("t2_frozen_valid", 32'(s_id_valid), 32'd1);
      chk("t2_frozen_pc", s_id_pc, frozen);
    end
    chk("t2_no_req_when_full", 32'(s_req_valid), 32'd0);
    chk("t2_credits", 32'(live), 32'd4);
    stall = 1'b0;
    cycle();
    chk("t2_resume0", s_id_pc, frozen);
    cycle();
    chk("t2_resume1", s_id_pc, frozen + 32'd4);
    repeat (4) cycle();

    // redirect to 0x100 with two requests in flight at latency 3
    lat = 3;
    req_ready = 1'b0;
    repeat (4) cycle();
    req_ready = 1'b1;
    cycle();
    cycle();
    redir_valid = 1'b1; redir_pc = 32'h100;
    cycle();
    redir_valid = 1'b0;
    cycle();
    chk("t3_id_valid_after", 32'(s_id_valid), 32'd0);
    chk("t3_req_valid_after", 32'(s_req_valid), 32'd1);
    chk("t3_req_target", s_req_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_id_valid) found = 1'b1;
    end
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_first_pc", s_id_pc, 32'h100);
    cycle();
    chk("t3_second_pc", s_id_pc, 32'h104);

    // redirect coincident with stall and a returning response, latency 2
    req_ready = 1'b0;
    repeat (4) cycle();
    lat = 2;
    req_ready = 1'b1;
    repeat (4) cycle();
    stall = 1'b1;
    cycle();
    redir_valid = 1'b1; redir_pc = 32'h300;
    cycle();
    chk("t4_pre_valid", 32'(s_id_valid), 32'd1);
    redir_valid = 1'b0; stall = 1'b0;
    cycle();
    chk("t4_flushed", 32'(s_id_valid), 32'd0);
    chk("t4_req_target", s_req_addr, 32'h300);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_id_valid) found = 1'b1;
    end
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_first_pc", s_id_pc, 32'h300);
    repeat (3) cycle();

    // random ready at latency 3, misaligned redirect target
    lat = 3;
    rand_ready = 1'b1;
    repeat (10) cycle();
    redir_valid = 1'b1; redir_pc = 32'h203;
    cycle();
    redir_valid = 1'b0;
    cycle();
    chk("t5_req_valid", 32'(s_req_valid), 32'd1);
    chk("t5_req_target", s_req_addr, 32'h200);
    repeat (40) cycle();
    rand_ready = 1'b0;
    req_ready = 1'b1;
    repeat (8) cycle();
    repeat (4) begin
      cycle();
      chk("t5_throughput_lat3", 32'(s_id_valid), 32'd1);
    end

    // asynchronous reset with the buffer full
    req_ready = 1'b0;
    repeat (4) cycle();
    lat = 1;
    req_ready = 1'b1;
    stall = 1'b1;
    repeat (6) cycle();
    chk("t6_full_valid", 32'(s_id_valid), 32'd1);
    chk("t6_full_live", 32'(live), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_id_valid", 32'(id_valid), 32'd0);
    chk("t6_rst_id_instr", id_instr, NOP_INSTR);
    chk("t6_rst_id_pc", id_pc, 32'h0);
    chk("t6_rst_id_pc4", id_pc4, 32'h4);
    chk("t6_rst_req_valid", 32'(req_valid), 32'd0);
    pend.delete();
    live = 0;
    exp_pc = 32'h0;
    exp_req = 32'h0;
    stall = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("t6_refetch_valid", 32'(s_req_valid), 32'd1);
    chk("t6_refetch_addr", s_req_addr, 32'h0);
    repeat (8) cycle();

    chk("stream_progress", 32'(pops > 40), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
